// File: rtl/hs_pkg.sv
// Shared types and default parameters for the hs_req_master request link.
//   hs_state_e : link FSM state (IDLE, REQ)
//   hs_cmd_t   : queued write command payload {addr, data} at default widths
package hs_pkg;

  localparam int unsigned HS_ADDR_W  = 2;
  localparam int unsigned HS_DATA_W  = 4;
  localparam int unsigned HS_DEPTH   = 4;
  localparam int unsigned HS_TIMEOUT = 16;
  localparam int unsigned HS_CNT_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } hs_state_e;

  typedef struct packed {
    logic [HS_ADDR_W-1:0] addr;
    logic [HS_DATA_W-1:0] data;
  } hs_cmd_t;

endpackage

// File: rtl/hs_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of W bits, first-word fall-through.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointers only)
//   push, wdata   : enqueue when not full
//   pop, rdata    : dequeue when not empty; rdata shows the head entry
//   full, empty   : occupancy flags derived from the pre-edge pointers
//   count         : entries currently stored
module hs_cmd_fifo
  import hs_pkg::*;
#(
  parameter int unsigned W     = HS_ADDR_W + HS_DATA_W,
  parameter int unsigned DEPTH = HS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/hs_req_master.sv
// Request master for the addr/data valid/ready link: queues write commands and
// issues them one at a time, counting completions and flagging errors.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   cmd_push/cmd_addr/cmd_data  : enqueue a command
//   cmd_full, cmd_count         : queue status
//   valid/ready/addr/data       : link handshake and registered payload
//   busy                        : valid high or commands still queued
//   done_cnt                    : completed handshakes (wrapping)
//   overflow, timeout_err       : sticky error flags, cleared by err_clr
module hs_req_master
  import hs_pkg::*;
#(
  parameter int unsigned ADDR_W  = HS_ADDR_W,
  parameter int unsigned DATA_W  = HS_DATA_W,
  parameter int unsigned DEPTH   = HS_DEPTH,
  parameter int unsigned TIMEOUT = HS_TIMEOUT,
  parameter int unsigned CNT_W   = HS_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_push,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic                     cmd_full,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic                     valid,
  input  logic                     ready,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        data,
  output logic                     busy,
  output logic [CNT_W-1:0]         done_cnt,
  output logic                     overflow,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int unsigned W      = ADDR_W + DATA_W;
  localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  hs_state_e         state_q;
  hs_state_e         state_d;
  logic              pop;
  logic              empty;
  logic [W-1:0]      head;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_nxt;
  logic              to_hit;
  logic              ovf_hit;
  logic              xfer;

  hs_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .wdata ({cmd_addr, cmd_data}),
    .pop   (pop),
    .rdata (head),
    .full  (cmd_full),
    .empty (empty),
    .count (cmd_count)
  );

  assign valid = (state_q == REQ);
  assign busy  = valid | (cmd_count != '0);
  assign xfer  = valid && ready;

  // Fullness is judged before the edge, so a same-cycle pop cannot rescue a push.
  assign ovf_hit = cmd_push && cmd_full;

  // Saturating wait counter; the flag re-asserts every cycle it stays saturated.
  assign wait_nxt = (wait_q == WAIT_W'(TIMEOUT)) ? wait_q : wait_q + WAIT_W'(1);
  assign to_hit   = (TIMEOUT != 0) && valid && !ready && (wait_nxt == WAIT_W'(TIMEOUT));

  // Next-state: every exit from REQ passes through IDLE, forcing a valid-low gap.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, payload, counters and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr        <= '0;
      data        <= '0;
      wait_q      <= '0;
      done_cnt    <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        {addr, data} <= head;
        wait_q       <= '0;
      end else if (valid && !ready) begin
        wait_q <= wait_nxt;
      end
      if (xfer) done_cnt <= done_cnt + CNT_W'(1);
      // A new error event beats a simultaneous clear.
      overflow    <= ovf_hit | (overflow & ~err_clr);
      timeout_err <= to_hit | (timeout_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_hs_req_master.sv
// Directed plus randomized bench for hs_req_master with a queue-level reference model.
module tb_hs_req_master;
  import hs_pkg::*;

  localparam int unsigned DEPTH   = HS_DEPTH;
  localparam int unsigned TIMEOUT = HS_TIMEOUT;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_push;
  logic [1:0] cmd_addr;
  logic [3:0] cmd_data;
  logic       cmd_full;
  logic [2:0] cmd_count;
  logic       valid;
  logic       ready;
  logic [1:0] addr;
  logic [3:0] data;
  logic       busy;
  logic [7:0] done_cnt;
  logic       overflow;
  logic       timeout_err;
  logic       err_clr;

  int total = 0;
  int bad   = 0;

  // Reference model state
  hs_cmd_t    q[$];
  logic       m_valid;
  logic [1:0] m_addr;
  logic [3:0] m_data;
  logic [7:0] m_done;
  logic       m_ovf;
  logic       m_to;
  int         m_wait;

  hs_req_master #(
    .ADDR_W(HS_ADDR_W), .DATA_W(HS_DATA_W), .DEPTH(HS_DEPTH),
    .TIMEOUT(HS_TIMEOUT), .CNT_W(HS_CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .cmd_push(cmd_push), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_full(cmd_full), .cmd_count(cmd_count),
    .valid(valid), .ready(ready), .addr(addr), .data(data), .busy(busy),
    .done_cnt(done_cnt), .overflow(overflow), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Link protocol: payload and valid held while waiting; valid drops after acceptance.
  a_hold: assert property (@(posedge clk) disable iff (rst)
                           (valid && !ready) |=> (valid && $stable(addr) && $stable(data)))
    else begin bad++; $error("FAIL sva_hold valid/addr/data changed while waiting for ready"); end
  a_drop: assert property (@(posedge clk) disable iff (rst) (valid && ready) |=> !valid)
    else begin bad++; $error("FAIL sva_drop valid still high after accepted transfer"); end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin bad++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end
  endtask

  // One clock edge of the reference model, using the inputs present at the edge.
  task automatic model_edge();
    int      pre;
    logic    to_evt;
    hs_cmd_t c;
    pre    = q.size();
    to_evt = 1'b0;
    if (rst) begin
      q.delete();
      m_valid = 1'b0; m_addr = '0; m_data = '0; m_done = '0;
      m_ovf = 1'b0; m_to = 1'b0; m_wait = 0;
      return;
    end
    if (m_valid) begin
      if (ready) begin
        m_valid = 1'b0;
        m_done  = m_done + 8'd1;
      end else begin
        if (m_wait < TIMEOUT) m_wait++;
        if (TIMEOUT != 0 && m_wait == TIMEOUT) to_evt = 1'b1;
      end
    end else if (pre != 0) begin
      c       = q.pop_front();
      m_addr  = c.addr;
      m_data  = c.data;
      m_valid = 1'b1;
      m_wait  = 0;
    end
    if (cmd_push && pre < DEPTH) begin
      c.addr = cmd_addr;
      c.data = cmd_data;
      q.push_back(c);
    end
    m_ovf = (cmd_push && pre == DEPTH) || (m_ovf && !err_clr);
    m_to  = to_evt || (m_to && !err_clr);
  endtask

  task automatic check_all();
    chk("valid",       32'(valid),       32'(m_valid));
    chk("addr",        32'(addr),        32'(m_addr));
    chk("data",        32'(data),        32'(m_data));
    chk("done_cnt",    32'(done_cnt),    32'(m_done));
    chk("cmd_count",   32'(cmd_count),   32'(q.size()));
    chk("cmd_full",    32'(cmd_full),    32'(q.size() == DEPTH));
    chk("busy",        32'(busy),        32'(m_valid || q.size() != 0));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic push_cyc(input logic [1:0] a, input logic [3:0] d);
    cmd_push = 1'b1; cmd_addr = a; cmd_data = d;
    cyc();
    cmd_push = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  initial begin
    logic [5:0] pat;
    int         thr;
    rst = 1'b1; cmd_push = 1'b0; cmd_addr = '0; cmd_data = '0;
    ready = 1'b0; err_clr = 1'b0;

    // Reset state
    cyc();
    rst = 1'b0;
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_count", 32'(cmd_count), 32'(0));
    chk("rst_done",  32'(done_cnt), 32'(0));

    // 1: single transfer held for two cycles of back-pressure
    do_reset();
    push_cyc(2'd0, 4'd0);
    chk("s1_idle_after_push", 32'(valid), 32'(0));
    cyc();
    chk("s1_valid_rise", 32'(valid), 32'(1));
    cyc(); cyc();
    chk("s1_valid_held", 32'(valid), 32'(1));
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    chk("s1_valid_drop", 32'(valid), 32'(0));
    chk("s1_done", 32'(done_cnt), 32'(1));

    // 2: three commands, ready tied high
    do_reset();
    ready = 1'b1;
    pat = '0;
    push_cyc(2'd1, 4'd1);
    push_cyc(2'd2, 4'd5);
    pat = {pat[4:0], valid};
    chk("s2_a0", 32'({addr, data}), 32'({2'd1, 4'd1}));
    push_cyc(2'd3, 4'd9);
    pat = {pat[4:0], valid};
    cyc(); pat = {pat[4:0], valid};
    chk("s2_a1", 32'({addr, data}), 32'({2'd2, 4'd5}));
    cyc(); pat = {pat[4:0], valid};
    cyc(); pat = {pat[4:0], valid};
    chk("s2_a2", 32'({addr, data}), 32'({2'd3, 4'd9}));
    cyc(); pat = {pat[4:0], valid};
    chk("s2_pattern", 32'(pat), 32'(6'b101010));
    chk("s2_done", 32'(done_cnt), 32'(3));
    chk("s2_busy", 32'(busy), 32'(0));
    ready = 1'b0;

    // 3: overfill the queue, then clear the sticky flag
    do_reset();
    for (int i = 0; i < 6; i++) push_cyc(2'(i), 4'(i + 1));
    chk("s3_count", 32'(cmd_count), 32'(DEPTH));
    chk("s3_full", 32'(cmd_full), 32'(1));
    chk("s3_ovf", 32'(overflow), 32'(1));
    err_clr = 1'b1;
    push_cyc(2'd0, 4'd0);
    chk("s3_clr_vs_ovf", 32'(overflow), 32'(1));
    cyc();
    err_clr = 1'b0;
    chk("s3_clr", 32'(overflow), 32'(0));

    // 4: ready timeout
    do_reset();
    push_cyc(2'd1, 4'd3);
    cyc();
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == TIMEOUT - 1) chk("s4_to_before", 32'(timeout_err), 32'(0));
      if (k == TIMEOUT)     chk("s4_to_at", 32'(timeout_err), 32'(1));
    end
    chk("s4_valid_held", 32'(valid), 32'(1));
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    chk("s4_done", 32'(done_cnt), 32'(1));
    chk("s4_to_sticky", 32'(timeout_err), 32'(1));
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("s4_to_clr", 32'(timeout_err), 32'(0));

    // 5: reset mid-transfer
    do_reset();
    push_cyc(2'd1, 4'd1); push_cyc(2'd2, 4'd2); push_cyc(2'd3, 4'd3);
    chk("s5_pre_valid", 32'(valid), 32'(1));
    chk("s5_pre_count", 32'(cmd_count), 32'(2));
    rst = 1'b1; ready = 1'b1;
    cyc();
    rst = 1'b0; ready = 1'b0;
    chk("s5_valid", 32'(valid), 32'(0));
    chk("s5_count", 32'(cmd_count), 32'(0));
    chk("s5_done", 32'(done_cnt), 32'(0));
    cyc();

    // 6: 256 transfers wrap done_cnt
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push_cyc(2'($urandom), 4'($urandom));
      cyc();
    end
    for (int i = 0; i < 4; i++) cyc();
    chk("s6_wrap", 32'(done_cnt), 32'(0));
    chk("s6_idle", 32'(busy), 32'(0));
    ready = 1'b0;

    // Random traffic with varying back-pressure
    do_reset();
    thr = 5;
    for (int i = 0; i < 1200; i++) begin
      if (i % 100 == 0) thr = int'($urandom_range(0, 10));
      rst      = ($urandom_range(0, 199) == 0);
      cmd_push = 1'($urandom);
      cmd_addr = 2'($urandom);
      cmd_data = 4'($urandom);
      ready    = (int'($urandom_range(0, 9)) < thr);
      err_clr  = ($urandom_range(0, 19) == 0);
      cyc();
    end
    rst = 1'b0; cmd_push = 1'b0; ready = 1'b0; err_clr = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
